cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common data bus (CDB) arbiter and broadcast stage for the out-of-order core. Each functional unit (ALU, branch unit, memory unit, and others) raises a request with its result and ROB tag. The arbiter captures each request in a one-entry holding buffer, grants exactly one buffered result per cycle in round-robin order, and drives the registered CDB broadcast consumed by reservation stations, the ROB and the register status table. It is the receiving end of the functional-unit request interface.

## Interface
Parameters:
- WIDTH, 31, MSB index of the result datapath (result is WIDTH+1 bits)
- ROB_W, 3, MSB index of the ROB tag
- NUM_FU, 4, number of functional-unit ports (2..8)
- SRC_W, 1, MSB index of the source-port index; must satisfy 2^(SRC_W+1) >= NUM_FU

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- fu_req  in  NUM_FU  per-unit result-valid request
- fu_result  in  NUM_FU×(WIDTH+1)  per-unit result, packed, unit i at [i*(WIDTH+1) +: WIDTH+1]
- fu_tag  in  NUM_FU×(ROB_W+1)  per-unit destination ROB tag, packed the same way
- fu_ready  out  NUM_FU  per-unit buffer can accept this cycle
- cdb_valid  out  1  broadcast valid
- cdb_result  out  WIDTH+1  broadcast result
- cdb_tag  out  ROB_W+1  broadcast ROB tag
- cdb_src  out  SRC_W+1  index of the unit that produced the broadcast
- flush  in  1  squash everything; present only with CDB_FLUSH_EN

## Operation
- Per-unit state: buf_valid[i], buf_result[i], buf_tag[i]. Global state: rr_ptr, which has SRC_W+1 bits.
- Grant is combinational: grant[i] is set for the first i with buf_valid[i]=1, searching rr_ptr, rr_ptr+1, …, wrapping modulo NUM_FU. At most one grant is set. The grant logic depends only on registered state and never on fu_req.
- fu_ready[i] = !buf_valid[i] | grant[i]. A buffer being drained this cycle can be refilled in the same cycle.
- Accept: on a clock edge where fu_req[i] & fu_ready[i], load buf_result[i] and buf_tag[i] and set buf_valid[i]=1.
- Drain: on an edge where grant[i] is set and no accept occurs on port i, clear buf_valid[i].
- Simultaneous drain and accept on the same port: the new data is loaded and buf_valid stays 1.
- fu_req[i] while fu_ready[i]=0 is ignored. The functional unit must hold its request until it sees ready.
- Broadcast register, updated every edge:
  - cdb_valid <= |grant
  - cdb_result, cdb_tag and cdb_src take the granted buffer's contents and index; they hold their values when there is no grant.
- Pointer: on a grant at index g, rr_ptr <= (g == NUM_FU-1) ? 0 : g+1. With no grant, rr_ptr is unchanged.
- Starvation bound: a buffered entry is broadcast within NUM_FU cycles of becoming valid.

## Timing
- Reset values (asynchronous): every buf_valid = 0, rr_ptr = 0, cdb_valid = 0, cdb_result = 0, cdb_tag = 0, cdb_src = 0. fu_ready is all ones after reset.
- Latency: a request accepted at edge E is granted during the cycle after E at the earliest, and is visible on the CDB after edge E+1. Minimum latency is 2 edges.
- Throughput: one broadcast per cycle in aggregate. A single unit issuing back-to-back with no contention also achieves one result per cycle.
- Reset asserted mid-operation discards all buffered results and any broadcast in flight.

## Configuration
- CDB_FLUSH_EN defined:
  - The flush port exists.
  - On an edge with flush=1, all buf_valid and cdb_valid are cleared, rr_ptr is reset to 0, and accepts on that edge are dropped.
  - fu_ready is all zeros while flush=1.
- CDB_FLUSH_EN undefined: there is no flush port, and only reset clears state.

## Test plan
- Reset behaviour: after reset, fu_ready=4'b1111 and cdb_valid=0. A single request on unit 2 with result 32'h0000_0005 and tag 3 produces cdb_valid=1, result 5, tag 3, src 2 after edge E+1, and cdb_valid=0 on the next cycle.
- Full contention: all four units request together with results 10, 11, 12, 13. The CDB shows src 0, 1, 2, 3 on consecutive cycles. fu_ready is 0 for units 1..3 until each is granted.
- Round-robin fairness: unit 0 holds its request continuously and unit 3 requests once. Unit 3 is broadcast within 4 cycles, and unit 0 is not granted twice in a row while unit 3 is pending.
- Back-to-back single unit: unit 1 requests on 5 consecutive cycles with values 1..5. The CDB shows 1..5 on 5 consecutive cycles and fu_ready[1] stays 1.
- Wrap-around: rr_ptr=3 with units 0 and 3 both valid. Unit 3 is granted first and rr_ptr wraps to 0, then unit 0 is granted.
- With CDB_FLUSH_EN: three buffers are valid and flush is pulsed. cdb_valid=0 on the next cycle, no stale result is ever broadcast, and rr_ptr=0.

Source files
------------

// File: rtl/cdb_if.sv
// Functional-unit request / CDB broadcast bundle for cdb_arbiter.
// master = functional-unit side, slave = arbiter side.
interface cdb_if #(
  parameter int WIDTH  = 31,
  parameter int ROB_W  = 3,
  parameter int NUM_FU = 4,
  parameter int SRC_W  = 1
);
  logic [NUM_FU-1:0]           fu_req;
  logic [NUM_FU*(WIDTH+1)-1:0] fu_result;
  logic [NUM_FU*(ROB_W+1)-1:0] fu_tag;
  logic [NUM_FU-1:0]           fu_ready;
  logic                        cdb_valid;
  logic [WIDTH:0]              cdb_result;
  logic [ROB_W:0]              cdb_tag;
  logic [SRC_W:0]              cdb_src;

  modport master (
    output fu_req, fu_result, fu_tag,
    input  fu_ready, cdb_valid, cdb_result, cdb_tag, cdb_src
  );
  modport slave (
    input  fu_req, fu_result, fu_tag,
    output fu_ready, cdb_valid, cdb_result, cdb_tag, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding buffer per functional unit, round-robin grant, registered broadcast.
// Optional squash port enabled by defining CDB_FLUSH_EN.

module cdb_slot #(
  parameter int WIDTH = 31,
  parameter int ROB_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           req,
  input  logic           grant,
  input  logic [WIDTH:0] result,
  input  logic [ROB_W:0] tag,
  output logic           ready,
  output logic           valid,
  output logic [WIDTH:0] result_q,
  output logic [ROB_W:0] tag_q
);
  logic accept;

  // A slot being drained this cycle may be refilled on the same edge.
  assign ready  = (!valid | grant) & !clr;
  assign accept = req & ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid    <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (accept) begin
      valid    <= 1'b1;
      result_q <= result;
      tag_q    <= tag;
    end else if (grant) begin
      valid <= 1'b0;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int WIDTH  = 31,
  parameter int ROB_W  = 3,
  parameter int NUM_FU = 4,
  parameter int SRC_W  = 1
) (
  input  logic clk,
  input  logic reset,
`ifdef CDB_FLUSH_EN
  input  logic flush,
`endif
  cdb_if.slave bus
);
  logic                       clr;
  logic [NUM_FU-1:0]          buf_valid, grant, ready;
  logic [NUM_FU-1:0][WIDTH:0] buf_result;
  logic [NUM_FU-1:0][ROB_W:0] buf_tag;
  logic [SRC_W:0]             rr_ptr, gidx, rr_nxt;
  logic                       any;
  logic [WIDTH:0]             sel_result, cdb_result_q;
  logic [ROB_W:0]             sel_tag, cdb_tag_q;
  logic [SRC_W:0]             cdb_src_q;
  logic                       cdb_valid_q;
  int                         best_d, best_i, d;

`ifdef CDB_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
    cdb_slot #(.WIDTH(WIDTH), .ROB_W(ROB_W)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .req      (bus.fu_req[i]),
      .grant    (grant[i]),
      .result   (bus.fu_result[i*(WIDTH+1) +: WIDTH+1]),
      .tag      (bus.fu_tag[i*(ROB_W+1) +: ROB_W+1]),
      .ready    (ready[i]),
      .valid    (buf_valid[i]),
      .result_q (buf_result[i]),
      .tag_q    (buf_tag[i])
    );
  end

  // Pick the valid slot at the smallest circular distance from rr_ptr.
  always_comb begin
    best_d = NUM_FU;
    best_i = 0;
    d      = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      d = (i >= int'(rr_ptr)) ? i - int'(rr_ptr) : i + NUM_FU - int'(rr_ptr);
      if (buf_valid[i] && d < best_d) begin
        best_d = d;
        best_i = i;
      end
    end
  end

  assign any    = |buf_valid;
  assign gidx   = best_i[SRC_W:0];
  assign rr_nxt = (best_i == NUM_FU-1) ? '0 : gidx + 1'b1;

  always_comb begin
    grant      = '0;
    sel_result = '0;
    sel_tag    = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (any && best_i == i) begin
        grant[i]   = 1'b1;
        sel_result = buf_result[i];
        sel_tag    = buf_tag[i];
      end
    end
  end

  // Payload holds its last value when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_valid_q  <= 1'b0;
      cdb_result_q <= '0;
      cdb_tag_q    <= '0;
      cdb_src_q    <= '0;
      rr_ptr       <= '0;
    end else if (clr) begin
      cdb_valid_q <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      cdb_valid_q <= any;
      if (any) begin
        cdb_result_q <= sel_result;
        cdb_tag_q    <= sel_tag;
        cdb_src_q    <= gidx;
        rr_ptr       <= rr_nxt;
      end
    end
  end

  assign bus.fu_ready   = ready;
  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_result = cdb_result_q;
  assign bus.cdb_tag    = cdb_tag_q;
  assign bus.cdb_src    = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter: cycle model of the arbitration rules plus a
// per-unit scoreboard that checks every accepted result is broadcast once, in bounded time.
module tb_cdb_arbiter;
  localparam int WIDTH = 31, ROB_W = 3, NUM_FU = 4, SRC_W = 1;
  localparam int DW = WIDTH+1, TW = ROB_W+1;

  logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
  always #5 clk = ~clk;

  cdb_if #(.WIDTH(WIDTH), .ROB_W(ROB_W), .NUM_FU(NUM_FU), .SRC_W(SRC_W)) bus ();

  cdb_arbiter #(.WIDTH(WIDTH), .ROB_W(ROB_W), .NUM_FU(NUM_FU), .SRC_W(SRC_W)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef CDB_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus.slave)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // functional-unit request queues (driver side)
  logic [DW-1:0] rq_res[NUM_FU][$];
  logic [TW-1:0] rq_tag[NUM_FU][$];
  // scoreboard of accepted, not-yet-broadcast results
  logic [DW-1:0] sb_res[NUM_FU][$];
  logic [TW-1:0] sb_tag[NUM_FU][$];
  int            sb_edge[NUM_FU][$];
  // observed broadcasts
  int            log_src[$], log_edge[$];
  logic [DW-1:0] log_res[$];
  logic [TW-1:0] log_tag[$];

  // reference model
  bit            m_val[NUM_FU];
  logic [DW-1:0] m_res[NUM_FU];
  logic [TW-1:0] m_tag[NUM_FU];
  int            m_ptr;
  bit            e_val;
  logic [DW-1:0] e_res;
  logic [TW-1:0] e_tag;
  int            e_src;
  int            ecount = 0;

  function automatic int m_grant();
    for (int k = 0; k < NUM_FU; k++)
      if (m_val[(m_ptr + k) % NUM_FU]) return (m_ptr + k) % NUM_FU;
    return -1;
  endfunction

  task automatic push(input int u, input logic [DW-1:0] r, input logic [TW-1:0] t);
    rq_res[u].push_back(r);
    rq_tag[u].push_back(t);
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_FU; i++) begin
      bus.fu_req[i] = (rq_res[i].size() > 0);
      bus.fu_result[i*DW +: DW] = (rq_res[i].size() > 0) ? rq_res[i][0] : '0;
      bus.fu_tag[i*TW +: TW]    = (rq_tag[i].size() > 0) ? rq_tag[i][0] : '0;
    end
  endtask

  // One clock cycle; called and returns at a falling edge.
  task automatic step();
    int g, s, lat;
    bit acc[NUM_FU];
    bit fl, rdy;
    drive();
    #1;
    g  = m_grant();
    fl = flush;
    for (int i = 0; i < NUM_FU; i++) begin
      rdy = !fl && (!m_val[i] || g == i);
      chk($sformatf("fu_ready[%0d]", i), bus.fu_ready[i], rdy);
      acc[i] = bus.fu_req[i] && rdy;
    end
    @(posedge clk);
    ecount++;
    if (fl) begin
      e_val = 1'b0;
      m_ptr = 0;
      for (int i = 0; i < NUM_FU; i++) begin
        m_val[i] = 1'b0;
        sb_res[i].delete(); sb_tag[i].delete(); sb_edge[i].delete();
      end
    end else begin
      e_val = (g >= 0);
      if (g >= 0) begin
        e_res = m_res[g]; e_tag = m_tag[g]; e_src = g;
        m_ptr = (g + 1) % NUM_FU;
        m_val[g] = 1'b0;
      end
      for (int i = 0; i < NUM_FU; i++)
        if (acc[i]) begin
          m_val[i] = 1'b1; m_res[i] = rq_res[i][0]; m_tag[i] = rq_tag[i][0];
        end
    end
    #1;
    chk("cdb_valid", bus.cdb_valid, e_val);
    chk("cdb_result", bus.cdb_result, e_res);
    chk("cdb_tag", bus.cdb_tag, e_tag);
    chk("cdb_src", bus.cdb_src, e_src);
    if (bus.cdb_valid) begin
      s = int'(bus.cdb_src);
      log_src.push_back(s); log_edge.push_back(ecount);
      log_res.push_back(bus.cdb_result); log_tag.push_back(bus.cdb_tag);
      if (s < NUM_FU && sb_res[s].size() > 0) begin
        lat = ecount - sb_edge[s][0];
        chk("sb_result", bus.cdb_result, sb_res[s][0]);
        chk("sb_tag", bus.cdb_tag, sb_tag[s][0]);
        chk("sb_latency_bound", (lat >= 1 && lat <= NUM_FU), 1);
        void'(sb_res[s].pop_front()); void'(sb_tag[s].pop_front()); void'(sb_edge[s].pop_front());
      end else begin
        chk("sb_unexpected_broadcast", 1, 0);
      end
    end
    for (int i = 0; i < NUM_FU; i++)
      if (acc[i]) begin
        sb_res[i].push_back(rq_res[i][0]); sb_tag[i].push_back(rq_tag[i][0]);
        sb_edge[i].push_back(ecount);
        void'(rq_res[i].pop_front()); void'(rq_tag[i].pop_front());
      end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Asynchronous reset asserted between edges, released on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      rq_res[i].delete(); rq_tag[i].delete();
      sb_res[i].delete(); sb_tag[i].delete(); sb_edge[i].delete();
      m_val[i] = 1'b0;
    end
    m_ptr = 0; e_val = 1'b0; e_res = '0; e_tag = '0; e_src = 0;
    drive();
    #1;
    chk("rst_cdb_valid", bus.cdb_valid, 0);
    chk("rst_cdb_result", bus.cdb_result, 0);
    chk("rst_cdb_tag", bus.cdb_tag, 0);
    chk("rst_cdb_src", bus.cdb_src, 0);
    chk("rst_fu_ready", bus.fu_ready, {NUM_FU{1'b1}});
    @(negedge clk);
    reset = 1'b0;
    log_src.delete(); log_edge.delete(); log_res.delete(); log_tag.delete();
  endtask

  initial begin
    int start, idx3, n0;
    for (int i = 0; i < NUM_FU; i++) drive();

    // single request on unit 2
    do_reset();
    start = ecount;
    push(2, 32'h5, 4'd3);
    run(3);
    chk("single_count", log_src.size(), 1);
    if (log_src.size() == 1) begin
      chk("single_src", log_src[0], 2);
      chk("single_res", log_res[0], 32'h5);
      chk("single_tag", log_tag[0], 3);
      chk("single_latency", log_edge[0] - start, 2);
    end
    chk("single_idle_after", bus.cdb_valid, 0);

    // full contention from pointer 0
    do_reset();
    for (int i = 0; i < NUM_FU; i++) push(i, 32'(10 + i), 4'(i));
    run(6);
    chk("cont_count", log_src.size(), 4);
    if (log_src.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk("cont_src", log_src[k], k);
        chk("cont_res", log_res[k], 10 + k);
        chk("cont_consecutive", log_edge[k] - log_edge[0], k);
      end

    // fairness: unit 0 saturating, unit 3 once
    do_reset();
    for (int k = 0; k < 6; k++) push(0, 32'(100 + k), 4'd0);
    push(3, 32'h33, 4'd7);
    run(9);
    idx3 = -1; n0 = 0;
    foreach (log_src[k]) if (log_src[k] == 3 && idx3 < 0) idx3 = k;
    for (int k = 0; k < idx3; k++) if (log_src[k] == 0) n0++;
    chk("fair_unit3_seen", idx3 >= 0, 1);
    chk("fair_unit0_before_3", n0 <= 1, 1);
    chk("fair_total", log_src.size(), 7);

    // back-to-back on unit 1
    do_reset();
    for (int k = 1; k <= 5; k++) push(1, 32'(k), 4'(k));
    run(7);
    chk("b2b_count", log_src.size(), 5);
    if (log_src.size() == 5)
      for (int k = 0; k < 5; k++) begin
        chk("b2b_res", log_res[k], k + 1);
        chk("b2b_consecutive", log_edge[k] - log_edge[0], k);
      end

    // wrap-around: unit 2 moves the pointer to 3, then units 0 and 3 arrive together
    do_reset();
    push(2, 32'd20, 4'd1);
    step();
    push(0, 32'd21, 4'd2);
    push(3, 32'd22, 4'd3);
    run(4);
    chk("wrap_count", log_src.size(), 3);
    if (log_src.size() == 3) begin
      chk("wrap_first", log_src[0], 2);
      chk("wrap_second", log_src[1], 3);
      chk("wrap_third", log_src[2], 0);
    end

`ifdef CDB_FLUSH_EN
    // flush with three buffers valid and the pointer at 1
    do_reset();
    push(0, 32'd40, 4'd0);
    step();
    for (int i = 1; i < NUM_FU; i++) push(i, 32'(40 + i), 4'(i));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_cdb_valid", bus.cdb_valid, 0);
    run(3);
    chk("flush_no_stale", log_src.size(), 1);
    push(3, 32'd50, 4'd5);
    push(0, 32'd51, 4'd6);
    run(4);
    chk("flush_after_count", log_src.size(), 3);
    if (log_src.size() == 3) chk("flush_ptr_zero", log_src[1], 0);
`endif

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_FU; i++)
        if (rq_res[i].size() < 3 && $urandom_range(0, 99) < 45)
          push(i, $urandom, 4'($urandom_range(0, 15)));
`ifdef CDB_FLUSH_EN
      flush = ($urandom_range(0, 199) == 0);
`endif
      step();
    end
    flush = 1'b0;
    run(20);
    for (int i = 0; i < NUM_FU; i++) begin
      chk("drain_scoreboard", sb_res[i].size(), 0);
      chk("drain_requests", rq_res[i].size(), 0);
    end

    // reset while traffic is in flight
    for (int i = 0; i < NUM_FU; i++) push(i, $urandom, 4'($urandom_range(0, 15)));
    run(2);
    do_reset();
    run(3);
    chk("midreset_no_broadcast", log_src.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
